mc_ctrl_fsm: RTL

- Multicycle main-control state machine for the 32-bit MIPS core.
- Decodes the 6-bit opcode and steps each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives the datapath enables and muxes, and produces the 2-bit aluop consumed by the ALU decoder: 00 = add, 01 = sub, 10 = use funct.
- Sits beside the ALU decoder inside the controller.

---
 rtl/mc_ctrl_fsm.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main-control FSM: steps each instruction through fetch/decode/
// execute/memory/writeback and drives Moore datapath controls plus aluop.
module mc_ctrl_fsm #(
    parameter int ILLEGAL_TRAP = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);
    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] RTYPEEX = 4'd6;
    localparam logic [3:0] RTYPEWB = 4'd7;
    localparam logic [3:0] BEQEX   = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] ADDIWB  = 4'd10;
    localparam logic [3:0] JEX     = 4'd11;
    localparam logic [3:0] HALT    = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [3:0] next;
    logic       pcwrite;
    logic       branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next;
    end

    always_comb begin
        next       = FETCH;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
                next    = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_RTYPE:     next = RTYPEEX;
                    OP_BEQ:       next = BEQEX;
                    OP_ADDI:      next = ADDIEX;
                    OP_J:         next = JEX;
                    default: begin
                        illegal = 1'b1;
                        next    = (ILLEGAL_TRAP != 0) ? HALT : FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                // op is re-sampled here; anything but sw is treated as a load
                next    = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord = 1'b1;
                next = MEMWB;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                next    = RTYPEWB;
            end
            RTYPEWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                aluop      = 2'b01;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                next    = ADDIWB;
            end
            ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            JEX: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
            end
            HALT: begin
                illegal = 1'b1;
                next    = HALT;
            end
            default: next = FETCH;
        endcase
    end

    assign pcen = pcwrite | (branch & zero);
endmodule
